// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: state encodings,
// default bit period, idle line level and the parity helper.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    // 50 MHz system clock at 115200 baud.
    localparam logic [15:0] DEF_CLKS_PER_BIT = 16'd434;
    localparam logic        TX_IDLE_LVL      = 1'b1;
    localparam logic [2:0]  LAST_DATA_BIT    = 3'd7;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side handshake between a synchronous 8-bit FIFO and its UART drain.
// The master (drain) issues read pulses; the slave (FIFO) supplies data and empty.
interface uart_tx_fifo_drain_if;

    logic [7:0] fifo_dout;
    logic       fifo_emptyp;
    logic       fifo_readp;

    modport master (
        input  fifo_dout,
        input  fifo_emptyp,
        output fifo_readp
    );

    modport slave (
        output fifo_dout,
        output fifo_emptyp,
        input  fifo_readp
    );

endinterface

// File: rtl/uart_tx_fifo_drain_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// period. Shared with a future receiver feeding the FIFO write side.
module uart_baud_cnt #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
    input  logic clk,
    input  logic rstp,
    input  logic clr,
    output logic tick
);

    logic [15:0] cnt_r;
    logic        last_s;

    assign last_s = (cnt_r == (CLKS_PER_BIT - 16'd1));
    assign tick   = last_s;

    // Period counter; clear realigns the period to a state entry.
    always_ff @(posedge clk) begin
        if (rstp) begin
            cnt_r <= 16'd0;
        end else if (clr || last_s) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1/8N2 transmitter that drains a synchronous FIFO, one read per frame.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit after the data.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 32'd1
) (
    input  logic                        clk,
    input  logic                        rstp,
    uart_tx_fifo_drain_if.master        fifo,
    output logic                        txd,
    output logic                        busy,
    output logic                        tx_done
);

    tx_state_e   state_r,    state_nxt_s;
    logic [7:0]  shift_r,    shift_nxt_s;
    logic [2:0]  bit_cnt_r,  bit_cnt_nxt_s;
    logic        stop_cnt_r, stop_cnt_nxt_s;
    logic        txd_r,      txd_nxt_s;
    logic        readp_r,    readp_nxt_s;
    logic        busy_r,     busy_nxt_s;
    logic        done_r,     done_nxt_s;
    logic        tick_s;
    logic        clr_s;
    logic        stop_last_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r,   parity_nxt_s;
`endif

    assign clr_s       = (state_nxt_s != state_r);
    assign stop_last_s = (STOP_BITS == 32'd2) ? stop_cnt_r : 1'b1;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rstp (rstp),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        stop_cnt_nxt_s = stop_cnt_r;
        done_nxt_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!fifo.fifo_emptyp) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            // An empty flag here means the FIFO was reset under us: no read.
            ST_WAIT: begin
                if (fifo.fifo_emptyp) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_nxt_s    = fifo.fifo_dout;
                bit_cnt_nxt_s  = 3'd0;
                stop_cnt_nxt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_nxt_s   = even_parity(fifo.fifo_dout);
`endif
                state_nxt_s    = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == LAST_DATA_BIT) begin
                        bit_cnt_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_nxt_s   = ST_PARITY;
`else
                        state_nxt_s   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            // The done pulse is registered, so it lands in the first idle cycle.
            ST_STOP: begin
                if (tick_s) begin
                    if (stop_last_s) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        stop_cnt_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        readp_nxt_s = (state_nxt_s == ST_LOAD);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_START:  txd_nxt_s = 1'b0;
            ST_DATA:   txd_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_nxt_s = parity_nxt_s;
`endif
            default:   txd_nxt_s = TX_IDLE_LVL;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rstp) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            txd_r      <= TX_IDLE_LVL;
            readp_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            txd_r      <= txd_nxt_s;
            readp_r    <= readp_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_nxt_s;
`endif
        end
    end

    assign fifo.fifo_readp = readp_r;
    assign txd             = txd_r;
    assign busy            = busy_r;
    assign tx_done         = done_r;

endmodule
